uart_rx: RTL and testbench

Serial-to-parallel UART receiver driven by the 16x oversampling tick of the baud-rate generator. It sits directly downstream of the generator. It synchronises the asynchronous `i_rx` line, detects and validates the start bit, and mid-samples each data bit. It then presents the received word with a one-cycle `o_rx_done` strobe to the consumer, typically the FIFO or interface stage.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 2-flop input synchroniser, start-bit validation, mid-bit sampling.
// Optional even-parity check is compiled in with `define UART_RX_PARITY_EN (adds o_parity_err).
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  // Tick counter must also reach STOP_TICKS-1, e.g. 31 for two stop bits.
  localparam int SW = ($clog2(STOP_TICKS) > 4) ? $clog2(STOP_TICKS) : 4;
  localparam int NW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] b;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= i_rx;
      rx_s      <= rx_meta;
      o_rx_done <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            s      <= '0;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (i_tick) begin
            if (s == SW'(7)) begin
              s <= '0;
              if (!rx_s) begin
                state <= DATA;
                n     <= '0;
              end else begin
                // Line went high again before mid-bit: treat as noise.
                state  <= IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        DATA: begin
          if (i_tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= {rx_s, b[DATA_BITS-1:1]};
              if (n == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (s == SW'(15)) begin
              s       <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (i_tick) begin
            if (s == SW'(STOP_TICKS - 1)) begin
              s           <= '0;
              o_data      <= b;
              o_frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              o_parity_err <= (^b) ^ par_bit;
`endif
              o_rx_done   <= 1'b1;
              o_busy      <= 1'b0;
              state       <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level model.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int STOP_TICKS = 16;
  // Short tick period keeps each frame to a few hundred clocks.
  localparam int TICK_DIV   = 5;
  localparam int BIT_CLKS   = 16 * TICK_DIV;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       ferr;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       busy;
  } strobe_t;

  strobe_t got[$];
  strobe_t expq[$];

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .STOP_TICKS(STOP_TICKS)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_tick     (tick),
    .i_rx       (rx),
    .o_data     (data),
    .o_rx_done  (done),
    .o_frame_err(ferr),
    .o_busy     (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(perr)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      tick = (cnt == TICK_DIV - 1);
      cnt  = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
    end
  end

  // Record every cycle in which the strobe is seen high.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      strobe_t e;
      e.data = data;
      e.ferr = ferr;
`ifdef UART_RX_PARITY_EN
      e.perr = perr;
`else
      e.perr = 1'b0;
`endif
      e.busy = busy;
      got.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int clks);
    @(negedge clk);
    rx = 1'b1;
    repeat (clks - 1) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  // A bad stop bit is held low through its middle, then released so the line
  // does not present a fresh start edge.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    if (stop) begin
      send_bit(1'b1);
    end else begin
      @(negedge clk);
      rx = 1'b0;
      repeat (12 * TICK_DIV - 1) @(negedge clk);
      rx = 1'b1;
      repeat (4 * TICK_DIV) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       st;
    logic       par;
    strobe_t    e;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_done", done, 0);
    check("rst_ferr", ferr, 0);
    check("rst_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", perr, 0);
`endif
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);

    // Good 0xA5 frame
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(BIT_CLKS);
    check("a5_count", got.size(), 1);
    if (got.size() > 0) begin
      check("a5_data", got[0].data, 8'hA5);
      check("a5_ferr", got[0].ferr, 0);
      check("a5_busy_at_strobe", got[0].busy, 0);
    end
    check("a5_busy_after", busy, 0);
    $display("frame 0xA5: strobes=%0d data=0x%0h", got.size(), data);
    got.delete();

    // Three-tick glitch while idle
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    check("glitch_count", got.size(), 0);
    check("glitch_data", data, 8'hA5);
    check("glitch_busy", busy, 0);
    $display("glitch: strobes=%0d data=0x%0h", got.size(), data);
    got.delete();

    // Framing error then a good frame clears it
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2 * BIT_CLKS);
    check("3c_count", got.size(), 1);
    check("3c_data", data, 8'h3C);
    check("3c_ferr", ferr, 1);
    $display("frame 0x3C bad stop: strobes=%0d ferr=%0b", got.size(), ferr);
    got.delete();
    send_frame(8'h11, 1'b0, 1'b1);
    idle(BIT_CLKS);
    check("11_count", got.size(), 1);
    check("11_data", data, 8'h11);
    check("11_ferr", ferr, 0);
    $display("frame 0x11: strobes=%0d ferr=%0b", got.size(), ferr);
    got.delete();

    // Back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(BIT_CLKS);
    check("b2b_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("b2b_data0", got[0].data, 8'h00);
      check("b2b_ferr0", got[0].ferr, 0);
      check("b2b_data1", got[1].data, 8'hFF);
      check("b2b_ferr1", got[1].ferr, 0);
    end
    $display("back-to-back 0x00/0xFF: strobes=%0d", got.size());
    got.delete();

    // Reset during data bit 4 of 0x55
    d = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    @(negedge clk);
    rx = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_data", data, 0);
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);
    check("midrst_count", got.size(), 0);
    got.delete();
    send_frame(8'h81, 1'b0, 1'b1);
    idle(BIT_CLKS);
    check("81_count", got.size(), 1);
    check("81_data", data, 8'h81);
    $display("reset mid 0x55 then 0x81: strobes=%0d data=0x%0h", got.size(), data);
    got.delete();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle(BIT_CLKS);
    check("p03_count", got.size(), 1);
    check("p03_perr", perr, 1);
    $display("parity 0x03/p1: perr=%0b", perr);
    got.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(BIT_CLKS);
    check("p07_count", got.size(), 1);
    check("p07_perr", perr, 0);
    $display("parity 0x07/p1: perr=%0b", perr);
    got.delete();
`endif

    // Random frames; gaps optional except after a bad stop bit
    for (int k = 0; k < 16; k++) begin
      d   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 3) != 0);
      par = 1'($urandom_range(0, 1));
      send_frame(d, par, st);
      e.data = d;
      e.ferr = ~st;
      e.perr = (^d) ^ par;
      e.busy = 1'b0;
      expq.push_back(e);
      $display("random frame %0d: data=0x%0h stop=%0b par=%0b", k, d, st, par);
      if (!st || ($urandom_range(0, 1) == 1)) idle(2 * BIT_CLKS);
    end
    idle(2 * BIT_CLKS);
    check("rand_count", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < got.size()) begin
        check($sformatf("rand%0d_data", i), got[i].data, expq[i].data);
        check($sformatf("rand%0d_ferr", i), got[i].ferr, expq[i].ferr);
`ifdef UART_RX_PARITY_EN
        check($sformatf("rand%0d_perr", i), got[i].perr, expq[i].perr);
`endif
      end
    end
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
